// File: rtl/user_data_chk.sv
// Receive-side frame checker for the user data generator pattern (0,1,2... per beat).
// Define USER_DATA_CHK_ERR_CAPTURE_EN to build the first-mismatch capture registers.
module user_data_chk #(
  parameter int P_FRAME_LEN   = 100,
  parameter int P_LOCK_FRAMES = 4,
  parameter int P_TIMEOUT     = 1024,
  parameter int P_CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [63:0]        s_axi_rx_tdata,
  input  logic [7:0]         s_axi_rx_tkeep,
  input  logic               s_axi_rx_tlast,
  input  logic               s_axi_rx_tvalid,
  output logic               o_frame_ok,
  output logic               o_frame_err,
  output logic [P_CNT_W-1:0] o_frame_cnt,
  output logic [P_CNT_W-1:0] o_err_cnt,
  output logic               o_lock,
  output logic               o_cap_valid,
  output logic [63:0]        o_cap_exp,
  output logic [63:0]        o_cap_got,
  output logic [15:0]        o_cap_beat
);

  localparam int TMR_W  = $clog2(P_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(P_LOCK_FRAMES + 1);
  localparam logic [15:0]       LAST_BEAT = 16'(P_FRAME_LEN - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(P_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(P_LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_e;

  state_e              state_q, state_d;
  logic [15:0]         beat_q, beat_d;
  logic                bad_q, bad_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                lock_q, lock_d;
  logic [P_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [P_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [15:0] cur_beat;
  logic        beat_good;
  logic        end_ok;
  logic        end_err;

  // In IDLE the incoming beat is always treated as beat 0
  assign cur_beat  = (state_q == S_IDLE) ? 16'd0 : beat_q;
  assign beat_good = (s_axi_rx_tdata == {48'd0, cur_beat}) &&
                     (s_axi_rx_tkeep == 8'hFF) &&
                     (s_axi_rx_tlast == (cur_beat == LAST_BEAT));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    bad_d   = bad_q;
    timer_d = timer_q;
    end_ok  = 1'b0;
    end_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (s_axi_rx_tvalid) begin
          if (s_axi_rx_tlast) begin
            end_err = 1'b1;
          end else begin
            state_d = S_RECV;
            beat_d  = 16'd1;
            bad_d   = !beat_good;
          end
        end
      end
      S_RECV: begin
        if (s_axi_rx_tvalid) begin
          timer_d = '0;
          if (s_axi_rx_tlast) begin
            end_ok  = !bad_q && beat_good;
            end_err = !(!bad_q && beat_good);
            state_d = S_IDLE;
            beat_d  = '0;
            bad_d   = 1'b0;
          end else if (cur_beat == LAST_BEAT) begin
            end_err = 1'b1;
            state_d = S_DISCARD;
            beat_d  = '0;
            bad_d   = 1'b0;
          end else begin
            beat_d = beat_q + 16'd1;
            bad_d  = bad_q | !beat_good;
          end
        end else if (timer_q == TMR_LAST) begin
          end_err = 1'b1;
          state_d = S_IDLE;
          timer_d = '0;
          beat_d  = '0;
          bad_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DISCARD: begin
        if (s_axi_rx_tvalid) begin
          timer_d = '0;
          if (s_axi_rx_tlast) state_d = S_IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame-end reporting: pulses, saturating counters and lock all move on the same edge
  always_comb begin
    ok_d        = end_ok;
    err_d       = end_err;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    if ((end_ok || end_err) && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
    if (end_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    if (end_err) lock_cnt_d = '0;
    else if (end_ok && (lock_cnt_q != LOCK_MAX)) lock_cnt_d = lock_cnt_q + 1'b1;
    lock_d = (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      bad_q       <= 1'b0;
      timer_q     <= '0;
      lock_cnt_q  <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      bad_q       <= bad_d;
      timer_q     <= timer_d;
      lock_cnt_q  <= lock_cnt_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      lock_q      <= lock_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_lock      = lock_q;

`ifdef USER_DATA_CHK_ERR_CAPTURE_EN
  logic        cap_taken_q, cap_taken_d;
  logic        cap_valid_q, cap_valid_d;
  logic [63:0] cap_exp_q, cap_exp_d;
  logic [63:0] cap_got_q, cap_got_d;
  logic [15:0] cap_beat_q, cap_beat_d;
  logic        cap_take;

  // Data is latched at the first bad beat; the valid flag waits for that frame's end pulse
  always_comb begin
    cap_take    = s_axi_rx_tvalid && (state_q != S_DISCARD) && !beat_good && !cap_taken_q;
    cap_taken_d = cap_taken_q | cap_take;
    cap_exp_d   = cap_exp_q;
    cap_got_d   = cap_got_q;
    cap_beat_d  = cap_beat_q;
    if (cap_take) begin
      cap_exp_d  = {48'd0, cur_beat};
      cap_got_d  = s_axi_rx_tdata;
      cap_beat_d = cur_beat;
    end
    cap_valid_d = cap_valid_q | ((end_ok || end_err) && (cap_taken_q || cap_take));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_taken_q <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_exp_q   <= '0;
      cap_got_q   <= '0;
      cap_beat_q  <= '0;
    end else begin
      cap_taken_q <= cap_taken_d;
      cap_valid_q <= cap_valid_d;
      cap_exp_q   <= cap_exp_d;
      cap_got_q   <= cap_got_d;
      cap_beat_q  <= cap_beat_d;
    end
  end

  assign o_cap_valid = cap_valid_q;
  assign o_cap_exp   = cap_valid_q ? cap_exp_q : 64'd0;
  assign o_cap_got   = cap_valid_q ? cap_got_q : 64'd0;
  assign o_cap_beat  = cap_valid_q ? cap_beat_q : 16'd0;
`else
  assign o_cap_valid = 1'b0;
  assign o_cap_exp   = '0;
  assign o_cap_got   = '0;
  assign o_cap_beat  = '0;
`endif

endmodule

// File: tb/tb_user_data_chk.sv
// Self-checking bench for user_data_chk: a table of single-frame cases plus
// hand-written sequences for lock, back-to-back, discard, timeout and mid-frame reset.
module tb_user_data_chk;

  logic        clk = 1'b0;
  logic        rstN;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        frameOk, frameErr, lock, capValid;
  logic [31:0] frameCnt, errCnt;
  logic [63:0] capExp, capGot;
  logic [15:0] capBeat;

  int checks = 0;
  int errors = 0;
  int okSeen = 0;
  int errSeen = 0;

  user_data_chk dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .s_axi_rx_tdata  (tdata),
    .s_axi_rx_tkeep  (tkeep),
    .s_axi_rx_tlast  (tlast),
    .s_axi_rx_tvalid (tvalid),
    .o_frame_ok      (frameOk),
    .o_frame_err     (frameErr),
    .o_frame_cnt     (frameCnt),
    .o_err_cnt       (errCnt),
    .o_lock          (lock),
    .o_cap_valid     (capValid),
    .o_cap_exp       (capExp),
    .o_cap_got       (capGot),
    .o_cap_beat      (capBeat)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    if (rstN) begin
      okSeen  = okSeen + int'(frameOk);
      errSeen = errSeen + int'(frameErr);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int          badBeat;
    logic [63:0] badData;
    logic [7:0]  badKeep;
    int          lastAt;
    int          len;
    int          expOk;
    int          expErr;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic sendFrame(input int len, input int lastAt, input int badBeat,
                           input logic [63:0] badData, input logic [7:0] badKeep);
    for (int n = 0; n < len; n++) begin
      if (n == badBeat) applyStimulus(badData, badKeep, n == lastAt);
      else              applyStimulus(64'(n), 8'hFF, n == lastAt);
    end
  endtask

  int expFrames, expErrs, goodRun, okB, errB;

  initial begin
    vecs[0] = '{-1, 64'd0,  8'hFF, 99, 100, 1, 0};
    vecs[1] = '{37, 64'd38, 8'hFF, 99, 100, 0, 1};
    vecs[2] = '{99, 64'd99, 8'h7F, 99, 100, 0, 1};
    vecs[3] = '{-1, 64'd0,  8'hFF, 49, 50,  0, 1};
    vecs[4] = '{-1, 64'd0,  8'hFF, 0,  1,   0, 1};
    vecs[5] = '{-1, 64'd0,  8'hFF, 99, 100, 1, 0};
    vecs[6] = '{99, 64'd0,  8'hFF, 99, 100, 0, 1};

    rstN = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    idle(3);
    checkOutput("rst_ok", frameOk, 0);
    checkOutput("rst_err", frameErr, 0);
    checkOutput("rst_fcnt", frameCnt, 0);
    checkOutput("rst_ecnt", errCnt, 0);
    checkOutput("rst_lock", lock, 0);
    checkOutput("rst_cap", capValid, 0);
    rstN = 1'b1;
    idle(1);

    // Five clean frames back-to-back; lock rises with frame 4's pulse
    for (int f = 0; f < 5; f++) begin
      sendFrame(100, 99, -1, 0, 8'hFF);
      checkOutput("t1_ok", frameOk, 1);
      checkOutput("t1_lock", lock, (f >= 3) ? 1 : 0);
    end
    idle(2);
    checkOutput("t1_okseen", okSeen, 5);
    checkOutput("t1_fcnt", frameCnt, 5);
    checkOutput("t1_ecnt", errCnt, 0);
    expFrames = 5; expErrs = 0; goodRun = 5;

    for (int i = 0; i < 7; i++) begin
      okB = okSeen; errB = errSeen;
      sendFrame(vecs[i].len, vecs[i].lastAt, vecs[i].badBeat, vecs[i].badData, vecs[i].badKeep);
      idle(2);
      expFrames += vecs[i].expOk + vecs[i].expErr;
      expErrs   += vecs[i].expErr;
      goodRun = (vecs[i].expErr != 0) ? 0 : goodRun + 1;
      checkOutput($sformatf("vec%0d_ok", i), okSeen - okB, vecs[i].expOk);
      checkOutput($sformatf("vec%0d_err", i), errSeen - errB, vecs[i].expErr);
      checkOutput($sformatf("vec%0d_fcnt", i), frameCnt, expFrames);
      checkOutput($sformatf("vec%0d_ecnt", i), errCnt, expErrs);
      checkOutput($sformatf("vec%0d_lock", i), lock, (goodRun >= 4) ? 1 : 0);
    end

`ifdef USER_DATA_CHK_ERR_CAPTURE_EN
    checkOutput("cap_valid", capValid, 1);
    checkOutput("cap_beat", capBeat, 37);
    checkOutput("cap_exp", capExp, 37);
    checkOutput("cap_got", capGot, 38);
`else
    checkOutput("cap_off_valid", capValid, 0);
    checkOutput("cap_off_got", capGot, 0);
`endif

    // Early tlast then a clean frame with no bubble
    okB = okSeen; errB = errSeen;
    sendFrame(50, 49, -1, 0, 8'hFF);
    checkOutput("t3_err", frameErr, 1);
    sendFrame(100, 99, -1, 0, 8'hFF);
    checkOutput("t3_ok", frameOk, 1);
    idle(2);
    checkOutput("t3_okseen", okSeen - okB, 1);
    checkOutput("t3_errseen", errSeen - errB, 1);
    checkOutput("t3_fcnt", frameCnt, expFrames + 2);
    expFrames += 2; expErrs += 1;

    // Missing tlast at beat 99, junk beats discarded silently, then a clean frame
    okB = okSeen; errB = errSeen;
    sendFrame(100, -1, -1, 0, 8'hFF);
    checkOutput("t4_err", frameErr, 1);
    for (int j = 0; j < 5; j++) applyStimulus(64'hDEAD_0000 + 64'(j), 8'hFF, 1'b0);
    applyStimulus(64'hDEAD_BEEF, 8'h0F, 1'b1);
    idle(1);
    checkOutput("t4_junk_err", errSeen - errB, 1);
    checkOutput("t4_junk_ok", okSeen - okB, 0);
    sendFrame(100, 99, -1, 0, 8'hFF);
    idle(2);
    checkOutput("t4_ok", okSeen - okB, 1);
    checkOutput("t4_ecnt", errCnt, expErrs + 1);
    expFrames += 2; expErrs += 1;

    // Timeout after beat 10
    sendFrame(11, -1, -1, 0, 8'hFF);
    idle(1023);
    checkOutput("t5_early", frameErr, 0);
    idle(1);
    checkOutput("t5_err", frameErr, 1);
    idle(1);
    sendFrame(100, 99, -1, 0, 8'hFF);
    checkOutput("t5_ok", frameOk, 1);
    idle(1);
    checkOutput("t5_fcnt", frameCnt, expFrames + 2);

    // Reset mid-frame, then a clean frame
    okB = okSeen; errB = errSeen;
    for (int n = 0; n < 50; n++) applyStimulus(64'(n), 8'hFF, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("t6_rst_fcnt", frameCnt, 0);
    checkOutput("t6_rst_ecnt", errCnt, 0);
    checkOutput("t6_rst_lock", lock, 0);
    checkOutput("t6_rst_cap", capValid, 0);
    idle(2);
    rstN = 1'b1;
    idle(1);
    sendFrame(100, 99, -1, 0, 8'hFF);
    checkOutput("t6_ok", frameOk, 1);
    idle(2);
    checkOutput("t6_fcnt", frameCnt, 1);
    checkOutput("t6_ecnt", errCnt, 0);
    checkOutput("t6_pulses", (okSeen - okB) * 16 + (errSeen - errB), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
